// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch FSM reading program memory at the PC, stepping/loading the PC, issuing to decode.
// Latency: 3 cycles per one-byte op and 5 per two-byte op with zero-wait memory; a redirect adds 1 REDIR cycle.
// Backpressure: instruction held in ISSUE while instr_ready is low; memory reads are held until mem_ack.
module fetch_sequencer #(
    parameter logic [7:0] LONG_OP_MASK = 8'h80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] pc_in,
    output logic       inc_pr,
    output logic       load_ar_2_pr,
    output logic [7:0] data_on_pr,
    output logic       mem_rd,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_data,
    input  logic       br_req,
    input  logic [7:0] br_addr,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] opcode,
    output logic [7:0] operand,
    output logic [7:0] instr_pc
);

    typedef enum logic [2:0] {
        IDLE,
        OP_REQ,
        OP_INC,
        ARG_REQ,
        ARG_INC,
        ISSUE,
        REDIR
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       br_pend;
    logic [7:0] br_target;
    logic       branch_pending;
    logic       long_op;

    // A redirect counts as pending in the very cycle br_req arrives, not only once registered.
    assign branch_pending = br_pend | br_req;
    assign long_op        = (opcode & LONG_OP_MASK) != 8'h00;

    // The read address is only meaningful while a read is outstanding.
    assign mem_addr = mem_rd ? pc_in : 8'h00;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Redirect bookkeeping: latest br_req wins, REDIR consumes whatever is pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_pend   <= 1'b0;
            br_target <= 8'h00;
        end else begin
            if (br_req) begin
                br_target <= br_addr;
            end
            if (state == REDIR) begin
                br_pend <= 1'b0;
            end else if (br_req) begin
                br_pend <= 1'b1;
            end
        end
    end

    // Capture fetched bytes; a new opcode clears the operand so one-byte ops present 8'h00.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode   <= 8'h00;
            operand  <= 8'h00;
            instr_pc <= 8'h00;
        end else begin
            if (state == OP_REQ && mem_ack) begin
                opcode   <= mem_data;
                operand  <= 8'h00;
                instr_pc <= pc_in;
            end else if (state == ARG_REQ && mem_ack) begin
                operand <= mem_data;
            end
        end
    end

    // Next-state and per-state control pulses; branches are only taken at INC, ISSUE, IDLE.
    always_comb begin
        state_nxt    = state;
        inc_pr       = 1'b0;
        load_ar_2_pr = 1'b0;
        mem_rd       = 1'b0;
        instr_valid  = 1'b0;
        data_on_pr   = br_target;
        case (state)
            IDLE: begin
                if (branch_pending) begin
                    state_nxt = REDIR;
                end else if (run) begin
                    state_nxt = OP_REQ;
                end
            end
            OP_REQ: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    state_nxt = OP_INC;
                end
            end
            OP_INC: begin
                inc_pr = 1'b1;
                if (branch_pending) begin
                    state_nxt = REDIR;
                end else if (long_op) begin
                    state_nxt = ARG_REQ;
                end else begin
                    state_nxt = ISSUE;
                end
            end
            ARG_REQ: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    state_nxt = ARG_INC;
                end
            end
            ARG_INC: begin
                inc_pr = 1'b1;
                if (branch_pending) begin
                    state_nxt = REDIR;
                end else begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // A registered redirect squashes the held instruction; a coincident one lets it go first.
                instr_valid = ~br_pend;
                if (br_pend) begin
                    state_nxt = REDIR;
                end else if (instr_ready) begin
                    if (br_req) begin
                        state_nxt = REDIR;
                    end else if (run) begin
                        state_nxt = OP_REQ;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            REDIR: begin
                load_ar_2_pr = 1'b1;
                if (br_req) begin
                    data_on_pr = br_addr;
                end
                state_nxt = run ? OP_REQ : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
